aes_inv_cipher_iter: RTL

Iterative AES inverse cipher (FIPS-197 §5.3). Decrypts one 128-bit block, one round per clock. Pairs with the forward cipher datapath and uses the same opaque AES state type. Round keys come from an external expanded-key store, addressed by this block; the key store is combinational, with same-cycle read.

---
 rtl/aes_pkg.sv | 84 ++++++++
 rtl/aes_inv_round.sv | 31 +++
 rtl/aes_inv_cipher_iter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, the inverse S-box and pure helpers for the inverse round.
// State byte 4c+r (column c, row r) sits at bits 127-8*(4c+r) -: 8.
package aes_pkg;

  typedef logic [7:0]   t_byte;
  typedef logic [127:0] t_opaque_AESState;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } t_inv_state;

  localparam t_byte INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic bit nr_is_legal(input int nr);
    return (nr == 10) || (nr == 12) || (nr == 14);
  endfunction

  function automatic t_byte get_byte(input t_opaque_AESState s, input int c, input int r);
    return s[8*(15-(4*c+r)) +: 8];
  endfunction

  function automatic t_byte xtime(input t_byte b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic t_opaque_AESState inv_shift_rows(input t_opaque_AESState s);
    t_opaque_AESState o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(4*c+r)) +: 8] = get_byte(s, (c - r + 4) % 4, r);
      end
    end
    return o;
  endfunction

  // Multiples 9/11/13/14 built from a chained x2 -> x4 -> x8 ladder.
  function automatic t_opaque_AESState inv_mix_columns(input t_opaque_AESState s);
    t_opaque_AESState o;
    t_byte a [4];
    t_byte m9 [4];
    t_byte m11 [4];
    t_byte m13 [4];
    t_byte m14 [4];
    t_byte x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]   = get_byte(s, c, r);
        x2     = xtime(a[r]);
        x4     = xtime(x2);
        x8     = xtime(x4);
        m9[r]  = x8 ^ a[r];
        m11[r] = x8 ^ x2 ^ a[r];
        m13[r] = x8 ^ x4 ^ a[r];
        m14[r] = x8 ^ x4 ^ x2;
      end
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(4*c+r)) +: 8] = m14[r] ^ m11[(r+1)%4] ^ m13[(r+2)%4] ^ m9[(r+3)%4];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  t_opaque_AESState state_i,
  input  logic [127:0]     rk_i,
  input  logic             last_i,
  output t_opaque_AESState state_o
);

  t_opaque_AESState shifted_s;
  t_opaque_AESState subbed_s;
  t_opaque_AESState keyed_s;

  // Round datapath.
  always_comb begin
    shifted_s = inv_shift_rows(state_i);
    subbed_s  = '0;
    for (int i = 0; i < 16; i++) begin
      subbed_s[8*i +: 8] = INV_SBOX[shifted_s[8*i +: 8]];
    end
    keyed_s = subbed_s ^ rk_i;
    if (last_i) begin
      state_o = keyed_s;
    end else begin
      state_o = inv_mix_columns(keyed_s);
    end
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, round keys read from an
// external combinational key store addressed by rk_addr.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int RK_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     ciphertext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     plaintext,
  output logic [RK_AW-1:0] rk_addr,
  input  logic [127:0]     rk,
  output logic             busy
);

  if (!nr_is_legal(NR)) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end
  if ((1 << RK_AW) <= NR) begin : g_bad_aw
    $error("aes_inv_cipher_iter: RK_AW too narrow to address round key NR");
  end

  localparam logic [RK_AW-1:0] RK_LAST  = RK_AW'(NR);
  localparam logic [RK_AW-1:0] CNT_INIT = RK_AW'(NR - 1);

  t_inv_state       state_q, state_d;
  t_opaque_AESState st_q, st_d, round_s;
  logic [127:0]     pt_q, pt_d;
  logic [RK_AW-1:0] cnt_q, cnt_d;
  logic [RK_AW-1:0] rk_addr_q, rk_addr_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             last_s;

  assign last_s = (cnt_q == '0);

  aes_inv_round u_round (
    .state_i (st_q),
    .rk_i    (rk),
    .last_i  (last_s),
    .state_o (round_s)
  );

  // Next state and registered-output decode; outputs follow the next state.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          st_d    = ciphertext ^ rk;
          cnt_d   = CNT_INIT;
          state_d = S_ROUND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUND: begin
        st_d = round_s;
        if (last_s) begin
          pt_d    = round_s;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - RK_AW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d == S_ROUND);
    case (state_d)
      S_IDLE:  rk_addr_d = RK_LAST;
      S_ROUND: rk_addr_d = cnt_d;
      default: rk_addr_d = '0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      pt_q        <= '0;
      cnt_q       <= '0;
      rk_addr_q   <= RK_LAST;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      pt_q        <= pt_d;
      cnt_q       <= cnt_d;
      rk_addr_q   <= rk_addr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign plaintext = pt_q;
  assign rk_addr   = rk_addr_q;
  assign busy      = busy_q;

endmodule
